// File: rtl/ifpix_bcast.sv
// Input-feature pixel broadcaster: FIFO-buffered pixels are broadcast to NPad pads
// and retire only on an all-ready join of the enabled pads, counted per burst.
module ifpix_bcast #(
  parameter int DWd   = 16,
  parameter int NPad  = 4,
  parameter int Depth = 8,
  parameter int LenWd = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cont_start,
  input  logic [LenWd-1:0] i_cont_len,
  input  logic [NPad-1:0]  i_cont_mask,
  input  logic             i_cont_stall,
  output logic             o_cont_busy,
  output logic             o_cont_done,
  input  logic             i_src_valid,
  output logic             o_src_ready,
  input  logic [DWd-1:0]   i_src_data,
  output logic             o_ipix_valid,
  input  logic [NPad-1:0]  i_ipix_ready,
  output logic [DWd-1:0]   o_ipix_data,
  output logic             o_ipix_zero
);

  localparam int AWd = $clog2(Depth);
  localparam logic [AWd:0] CntFull = (AWd+1)'(Depth);
  localparam logic [AWd:0] CntZero = {(AWd+1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DWd-1:0]   r_mem [Depth];
  logic [AWd-1:0]   r_wptr;
  logic [AWd-1:0]   r_rptr;
  logic [AWd:0]     r_count;
  logic [DWd-1:0]   r_head;
  state_t           r_state;
  logic [LenWd-1:0] r_len;
  logic [NPad-1:0]  r_mask;
  logic [LenWd-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_valid;
  logic             w_fire;
  logic [AWd-1:0]   w_rptr_nxt;
  logic [AWd:0]     w_count_nxt;
  logic [DWd-1:0]   w_head_nxt;

  // Handshake decode and next-cycle FIFO head; an empty FIFO presents zero.
  always_comb begin
    w_full     = (r_count == CntFull);
    w_empty    = (r_count == CntZero);
    w_push     = i_src_valid && !w_full;
    w_valid    = (r_state == ST_RUN) && !w_empty && !i_cont_stall;
    w_fire     = w_valid && (&(i_ipix_ready | ~r_mask));
    w_rptr_nxt = w_fire ? (r_rptr + AWd'(1)) : r_rptr;
    case ({w_push, w_fire})
      2'b10:   w_count_nxt = r_count + (AWd+1)'(1);
      2'b01:   w_count_nxt = r_count - (AWd+1)'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_count_nxt == CntZero) begin
      w_head_nxt = {DWd{1'b0}};
    end else if (w_push && (w_rptr_nxt == r_wptr)) begin
      w_head_nxt = i_src_data;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wptr] <= i_src_data;
    end
  end

  // FIFO pointers, registered head and burst FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= {AWd{1'b0}};
      r_rptr  <= {AWd{1'b0}};
      r_count <= CntZero;
      r_head  <= {DWd{1'b0}};
      r_state <= ST_IDLE;
      r_len   <= {LenWd{1'b0}};
      r_mask  <= {NPad{1'b0}};
      r_cnt   <= {LenWd{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AWd'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_cont_start) begin
            r_len  <= i_cont_len;
            r_mask <= i_cont_mask;
            r_cnt  <= {LenWd{1'b0}};
            r_busy <= 1'b1;
            if (i_cont_len != {LenWd{1'b0}}) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            r_cnt <= r_cnt + LenWd'(1);
            if (r_cnt == (r_len - LenWd'(1))) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_src_ready  = !w_full;
  assign o_ipix_valid = w_valid;
  assign o_ipix_data  = r_head;
  assign o_ipix_zero  = w_valid && (r_head == {DWd{1'b0}});
  assign o_cont_busy  = r_busy;
  assign o_cont_done  = r_done;

endmodule

// File: tb/tb_ifpix_bcast.sv
// Directed, table-driven bench for ifpix_bcast: each row is one clock cycle of
// inputs plus the outputs expected just before the following rising edge.
module tb_ifpix_bcast;

  logic        clk = 1'b0;
  logic        rst;
  logic        cont_start;
  logic [7:0]  cont_len;
  logic [3:0]  cont_mask;
  logic        cont_stall;
  logic        cont_busy;
  logic        cont_done;
  logic        src_valid;
  logic        src_ready;
  logic [15:0] src_data;
  logic        ipix_valid;
  logic [3:0]  ipix_ready;
  logic [15:0] ipix_data;
  logic        ipix_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [15:0] sd;
    logic        st;
    logic [7:0]  len;
    logic [3:0]  mask;
    logic        stall;
    logic [3:0]  rdy;
    logic        e_srdy;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_zero;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl [256];
  int   n = 0;

  ifpix_bcast #(.DWd(16), .NPad(4), .Depth(8), .LenWd(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cont_start (cont_start),
    .i_cont_len   (cont_len),
    .i_cont_mask  (cont_mask),
    .i_cont_stall (cont_stall),
    .o_cont_busy  (cont_busy),
    .o_cont_done  (cont_done),
    .i_src_valid  (src_valid),
    .o_src_ready  (src_ready),
    .i_src_data   (src_data),
    .o_ipix_valid (ipix_valid),
    .i_ipix_ready (ipix_ready),
    .o_ipix_data  (ipix_data),
    .o_ipix_zero  (ipix_zero)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic sv, input logic [15:0] sd,
                     input logic st, input logic [7:0] len, input logic [3:0] mask,
                     input logic stall, input logic [3:0] rdy,
                     input logic esr, input logic ev, input logic [15:0] ed,
                     input logic eb, input logic edn);
    tbl[n].rst     = r;
    tbl[n].sv      = sv;
    tbl[n].sd      = sd;
    tbl[n].st      = st;
    tbl[n].len     = len;
    tbl[n].mask    = mask;
    tbl[n].stall   = stall;
    tbl[n].rdy     = rdy;
    tbl[n].e_srdy  = esr;
    tbl[n].e_valid = ev;
    tbl[n].e_data  = ed;
    tbl[n].e_zero  = ev && (ed == 16'h0000);
    tbl[n].e_busy  = eb;
    tbl[n].e_done  = edn;
    n++;
  endtask

  task automatic check(input int idx, input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %h want %h", idx, name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cont_start = 1'b0; cont_len = 8'd0; cont_mask = 4'h0;
    cont_stall = 1'b0; src_valid = 1'b0; src_data = 16'h0000; ipix_ready = 4'h0;

    // Basic burst: 1,2,3,0; first row also checks the reset state.
    add(0,1,16'h0001, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0000,0,0);
    add(0,1,16'h0002, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0001,0,0);
    add(0,1,16'h0003, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0001,0,0);
    add(0,1,16'h0000, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0001,0,0);
    add(0,0,16'h0000, 1,8'd4,4'hF,0,4'hF, 1,0,16'h0001,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0001,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0002,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0003,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0000,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);
    // All-ready join: pad2 holds off for three cycles.
    add(0,1,16'h000A, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0000,0,0);
    add(0,1,16'h000B, 0,8'd0,4'h0,0,4'h0, 1,0,16'h000A,0,0);
    add(0,0,16'h0000, 1,8'd2,4'hF,0,4'hB, 1,0,16'h000A,0,0);
    for (int k = 0; k < 3; k++) add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hB, 1,1,16'h000A,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h000A,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h000B,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);
    // Pad2 masked out: its low ready no longer blocks.
    add(0,1,16'h000C, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0000,0,0);
    add(0,1,16'h000D, 0,8'd0,4'h0,0,4'h0, 1,0,16'h000C,0,0);
    add(0,0,16'h0000, 1,8'd2,4'hB,0,4'hB, 1,0,16'h000C,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hB, 1,1,16'h000C,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hB, 1,1,16'h000D,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hB, 1,0,16'h0000,1,1);
    // Stall mid-burst, start ignored in RUN, then len=0.
    add(0,1,16'h0020, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0000,0,0);
    add(0,1,16'h0021, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0020,0,0);
    add(0,1,16'h0022, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0020,0,0);
    add(0,0,16'h0000, 1,8'd3,4'hF,0,4'hF, 1,0,16'h0020,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0020,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,1,4'hF, 1,0,16'h0021,1,0);
    add(0,0,16'h0000, 1,8'd0,4'hF,1,4'hF, 1,0,16'h0021,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0021,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0022,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);
    add(0,0,16'h0000, 1,8'd0,4'hF,0,4'hF, 1,0,16'h0000,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,0,0);
    // FIFO full, refused 9th push, drain of 8 with pointer wrap.
    for (int k = 0; k < 8; k++)
      add(0,1,16'h0100 + 16'(k), 0,8'd0,4'h0,0,4'h0, 1,0,(k == 0) ? 16'h0000 : 16'h0100,0,0);
    add(0,1,16'h01FF, 0,8'd0,4'h0,0,4'h0, 0,0,16'h0100,0,0);
    add(0,0,16'h0000, 1,8'd8,4'hF,0,4'hF, 0,0,16'h0100,0,0);
    for (int k = 0; k < 8; k++)
      add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, (k > 0),1,16'h0100 + 16'(k),1,0);
    add(0,1,16'h0055, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);
    add(0,0,16'h0000, 1,8'd1,4'hF,0,4'hF, 1,0,16'h0055,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0055,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);
    // Simultaneous push/pop at occupancy 3 for 10 cycles.
    add(0,1,16'h0A00, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0000,0,0);
    add(0,1,16'h0A01, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0A00,0,0);
    add(0,1,16'h0A02, 0,8'd0,4'h0,0,4'h0, 1,0,16'h0A00,0,0);
    add(0,0,16'h0000, 1,8'd10,4'hF,0,4'hF, 1,0,16'h0A00,0,0);
    for (int k = 0; k < 10; k++)
      add(0,1,16'h0A03 + 16'(k), 0,8'd0,4'h0,0,4'hF, 1,1,16'h0A00 + 16'(k),1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0A0A,1,1);
    // Reset mid-burst: buffered words and burst dropped, no done pulse.
    add(0,0,16'h0000, 1,8'd5,4'hF,0,4'hF, 1,0,16'h0A0A,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0A0A,1,0);
    add(1,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0A0B,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,0,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,0,0);
    add(0,0,16'h0000, 1,8'd1,4'hF,0,4'hF, 1,0,16'h0000,0,0);
    add(0,1,16'h0077, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,1,16'h0077,1,0);
    add(0,0,16'h0000, 0,8'd0,4'h0,0,4'hF, 1,0,16'h0000,1,1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rst        = tbl[i].rst;
      src_valid  = tbl[i].sv;
      src_data   = tbl[i].sd;
      cont_start = tbl[i].st;
      cont_len   = tbl[i].len;
      cont_mask  = tbl[i].mask;
      cont_stall = tbl[i].stall;
      ipix_ready = tbl[i].rdy;
      #1;
      check(i, "src_ready", {15'd0, src_ready},  {15'd0, tbl[i].e_srdy});
      check(i, "valid",     {15'd0, ipix_valid}, {15'd0, tbl[i].e_valid});
      check(i, "data",      ipix_data,           tbl[i].e_data);
      check(i, "zero",      {15'd0, ipix_zero},  {15'd0, tbl[i].e_zero});
      check(i, "busy",      {15'd0, cont_busy},  {15'd0, tbl[i].e_busy});
      check(i, "done",      {15'd0, cont_done},  {15'd0, tbl[i].e_done});
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifpix_bcast.md
# ifpix_bcast

Input-feature pixel broadcaster: the transmit end of the PE pixel-bus handshake that the IF pads receive on. It buffers pixels from the IF buffer in a small FIFO and broadcasts each one to `NPad` PE pads on a shared data bus. A pixel retires only when every enabled pad is ready in the same cycle (all-ready join). A zero flag is attached for zero-skipping, and a burst FSM counts pixels per control-issued burst.

## Interface
- `DWd`, 16, pixel width
- `NPad`, 4, number of pads on the broadcast bus
- `Depth`, 8, FIFO depth in words, power of 2, at least 2
- `LenWd`, 8, width of the burst-length field

- `i_clk` input 1: clock, all logic on the rising edge
- `i_rst` input 1: reset, synchronous, active-high
- `i_cont_start` input 1: start a burst, sampled in IDLE only
- `i_cont_len` input LenWd: pixels in the burst, sampled with start
- `i_cont_mask` input NPad: pad enable, bit k=1 means pad k participates, sampled with start
- `i_cont_stall` input 1: suppresses `o_ipix_valid` while high
- `o_cont_busy` input-side status output 1: high in RUN and DONE
- `o_cont_done` output 1: one-cycle pulse at burst completion
- `i_src_valid` input 1: upstream pixel valid
- `o_src_ready` output 1: FIFO not full
- `i_src_data` input DWd: upstream pixel
- `o_ipix_valid` output 1: broadcast pixel valid
- `i_ipix_ready` input NPad: per-pad ready
- `o_ipix_data` output DWd: FIFO head
- `o_ipix_zero` output 1: `o_ipix_valid` AND (`o_ipix_data`==0)

## Operation
- **FIFO.**
  - Push = `i_src_valid` && `o_src_ready`; accepted in every FSM state.
  - `o_src_ready` = !full. There is no bypass, so push into a full FIFO is refused even when a pop occurs the same cycle.
  - Pop = fire (defined under RUN). Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo `Depth`. The count is `$clog2(Depth)+1` bits.
- **FSM states: IDLE, RUN, DONE.**
- **IDLE.**
  - `i_cont_start` latches `len_r`, `mask_r` and clears `cnt`.
  - If `len` != 0, go to RUN.
  - If `len` == 0, go to DONE; no pixel is sent.
- **RUN.**
  - `o_ipix_valid` = !empty && !`i_cont_stall`.
  - fire = `o_ipix_valid` && &(`i_ipix_ready` | ~`mask_r`).
  - If `mask_r` == 0, fire whenever valid.
  - Each fire increments `cnt`. A fire with `cnt` == `len_r`-1 moves to DONE.
  - `i_cont_start` is ignored in RUN.
- **DONE.**
  - `o_cont_done`=1 for exactly one cycle, then return to IDLE.
  - Remaining FIFO words stay buffered for the next burst.
- **Outside RUN.** `o_ipix_valid`=0 and no pop occurs.
- **Valid stability.** Once `o_ipix_valid` is raised, data is held stable until fire, unless `i_cont_stall` rises; a stall may drop valid.
- **Per-pad ready.** A pad that is ready while another enabled pad is not ready sees no transfer. Pads must treat a transfer as `o_ipix_valid` && (&ready of enabled pads); the block does not generate per-pad valid.

## Timing
- **Reset** (`i_rst`=1 at an edge):
  - state IDLE, FIFO empty, pointers and count 0, `cnt`=0, `len_r`=0, `mask_r`=0.
  - Outputs: `o_ipix_valid`=0, `o_ipix_zero`=0, `o_ipix_data`=0, `o_src_ready`=1 from the next cycle, `o_cont_busy`=0, `o_cont_done`=0.
  - Reset mid-burst discards the buffered pixels and the burst with no done pulse.
- **Start latency.** Start sampled at edge t puts the FSM in RUN at t+1. `o_ipix_valid` can be high at t+1 if the FIFO is non-empty.
- **Push latency.** A pixel pushed at edge t can appear at `o_ipix_data` at t+1.
- **Throughput.** One pixel per cycle when all enabled pads are ready and no stall.
- **Completion.** Last fire at edge t gives DONE at t+1 (`o_cont_done`=1) and IDLE at t+2. Earliest next start is sampled at t+2.
- **Outputs.** `o_ipix_data` is the registered FIFO head, driven without combinational input-to-output paths except via `i_cont_stall` into valid and zero.

## Test plan
- **Basic burst.** Reset; push 1,2,3,0; start len=4, mask=4'b1111, all ready=1.
  - Four fires on consecutive cycles with data 1,2,3,0.
  - `o_ipix_zero`=1 only on the 4th fire.
  - `o_cont_done` pulses once, 1 cycle after the last fire.
- **All-ready join.** len=2; pad2 ready=0 for 3 cycles, others 1.
  - No fire and data held for those 3 cycles.
  - Then fire when pad2 ready=1.
  - Repeat with mask=4'b1011: fires immediately despite pad2 ready=0.
- **FIFO full.** Push 8 words with no burst active.
  - `o_src_ready`=0 after the 8th; the 9th push is refused.
  - Start len=8: exactly the 8 words come out in order with pointer wrap; `o_src_ready` returns to 1 one cycle after the first pop.
- **Stall and len=0.**
  - Stall for 2 cycles mid-burst: `o_ipix_valid`=0 and no `cnt` change.
  - Start len=0: `o_cont_done` at the next cycle with no `o_ipix_valid`.
  - Start asserted in RUN: ignored.
- **Simultaneous push/pop.** FIFO at 3 words; push every cycle while firing every cycle for 10 cycles.
  - Count stays 3 and order is preserved.
  - `i_rst` mid-burst: all outputs take their reset values the next cycle and no done pulse occurs.
